// File: rtl/mlp_weight_bank_loader_if.sv
// Weight stream interface carrying row-major words into the bank loader.
// Latency: none (wires only).
// Backpressure: the source holds in_rsc_dat/in_rsc_vld until in_rsc_rdy is seen high.
// Signals: in_rsc_dat (weight word), in_rsc_vld (word valid), in_rsc_rdy (loader ready).
interface mlp_weight_bank_loader_if #(
  parameter int DATA_W = 18
);
  logic [DATA_W-1:0] in_rsc_dat;
  logic              in_rsc_vld;
  logic              in_rsc_rdy;

  // Host/DMA side drives words, loader side answers with ready.
  modport master (output in_rsc_dat, output in_rsc_vld, input in_rsc_rdy);
  modport slave  (input in_rsc_dat, input in_rsc_vld, output in_rsc_rdy);
endinterface

// File: rtl/mlp_weight_bank_loader.sv
// Streams row-major weights round-robin into NUM_BANKS banked RAM write ports.
// Latency: 1 cycle from accepted word to its wr_en/wr_addr/wr_dat strobe.
// Backpressure: in_rsc_rdy is high only in LOAD; in_rsc_vld low simply stalls.
// Ports: clk/rst (sync active-high), start/num_rows (load request), in_rsc (stream
//   slave), wr_en/wr_addr/wr_dat (bank write port), busy/done/err (status),
//   checksum (running sign-extended word sum when MLP_WLOAD_CHECKSUM_EN is defined,
//   otherwise tied to 0).
module mlp_weight_bank_loader #(
  parameter int DATA_W     = 18,
  parameter int NUM_BANKS  = 64,
  parameter int BANK_DEPTH = 784,
  parameter int ADDR_W     = $clog2(BANK_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W:0]        num_rows,
  mlp_weight_bank_loader_if.slave in_rsc,
  output logic [NUM_BANKS-1:0]   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_dat,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            checksum
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [BANK_W-1:0] bank_idx;
  logic [ADDR_W-1:0] row_idx;
  logic [ADDR_W:0]   rows_q;
  logic              accept;
  logic              start_ok;
  logic              rows_legal;
  logic              last_word;

  assign rows_legal = (num_rows != '0) && (num_rows <= (ADDR_W+1)'(BANK_DEPTH));
  assign last_word  = (bank_idx == LAST_BANK) &&
                      ({1'b0, row_idx} == (rows_q - (ADDR_W+1)'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && rows_legal) state_d = LOAD;
      LOAD:    if (accept && last_word) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs: ready is a pure function of state
  always_comb begin
    in_rsc.in_rsc_rdy = (state_q == LOAD);
    accept            = in_rsc.in_rsc_vld && (state_q == LOAD);
    start_ok          = start && rows_legal && (state_q == IDLE);
  end

  // Registered write port, counters and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_idx <= '0;
      row_idx  <= '0;
      rows_q   <= '0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_dat   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= '0;
      done  <= 1'b0;
      // Any start that does not launch a load is reported, whatever the state.
      err   <= start && !start_ok;
      // Following state_d makes busy rise after start and fall together with done.
      busy  <= (state_d == LOAD);
      if (start_ok) begin
        rows_q   <= num_rows;
        bank_idx <= '0;
        row_idx  <= '0;
      end
      if (accept) begin
        wr_en   <= NUM_BANKS'(1) << bank_idx;
        wr_addr <= row_idx;
        wr_dat  <= in_rsc.in_rsc_dat;
        done    <= last_word;
        if (bank_idx == LAST_BANK) begin
          bank_idx <= '0;
          row_idx  <= row_idx + ADDR_W'(1);
        end else begin
          bank_idx <= bank_idx + BANK_W'(1);
        end
      end
    end
  end

`ifdef MLP_WLOAD_CHECKSUM_EN
  logic [31:0] sum_q;

  // Updated on the accept edge so it moves together with the matching wr_en.
  always_ff @(posedge clk) begin
    if (rst)           sum_q <= '0;
    else if (start_ok) sum_q <= '0;
    else if (accept)   sum_q <= sum_q + 32'(signed'(in_rsc.in_rsc_dat));
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mlp_weight_bank_loader.sv
// Randomised bench for mlp_weight_bank_loader against a word-count reference model.
// Latency: checks every cycle at the falling edge against the model's expectation.
// Backpressure: the bench source holds each word until the model says it was taken.
module tb_mlp_weight_bank_loader;
  localparam int DW = 8;
  localparam int NB = 4;
  localparam int BD = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_rows;
  logic [NB-1:0] wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_dat;
  logic          busy, done, err;
  logic [31:0]   checksum;

  always #5 clk = ~clk;

  mlp_weight_bank_loader_if #(.DATA_W(DW)) in_if ();

  mlp_weight_bank_loader #(
    .DATA_W(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .in_rsc(in_if),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: a load accepts exactly rows*NB words, word k goes to
  // bank k%NB at address k/NB, and every effect shows one cycle later.
  bit            m_open = 0;
  bit            e_done = 0, e_err = 0, e_busy = 0;
  logic [NB-1:0] e_we = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_dat = '0;
  logic [31:0]   e_sum = '0;
  int            cnt = 0, total = 0;
  logic [DW-1:0] wq[$];
  int            n_wr = 0;
  logic [NB-1:0] last_we = '0;
  logic [AW-1:0] last_addr = '0;
  bit            prev_vld = 0;
  int            vld_mode = 0;
  bit            phase = 0;

  task automatic tick();
    bit idle, nx_done, nx_err;
    logic [NB-1:0] nx_we;
    @(negedge clk);
    check("in_rsc_rdy", 32'(in_if.in_rsc_rdy), 32'(m_open));
    check("wr_en", 32'(wr_en), 32'(e_we));
    if (e_we != '0) begin
      check("wr_addr", 32'(wr_addr), 32'(e_addr));
      check("wr_dat", 32'(wr_dat), 32'(e_dat));
    end
    if (!prev_vld) check("no_write_after_vld_low", 32'(wr_en), 32'(0));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(e_err));
    check("busy", 32'(busy), 32'(e_busy));
    check("checksum", checksum, e_sum);
    if (wr_en != '0) begin
      n_wr++;
      last_we   = wr_en;
      last_addr = wr_addr;
    end
    prev_vld = in_if.in_rsc_vld;

    if (rst) begin
      m_open = 0; e_we = '0; e_done = 0; e_err = 0; e_busy = 0; e_sum = '0;
    end else begin
      idle    = !m_open && !e_done;
      nx_we   = '0;
      nx_done = 0;
      nx_err  = 0;
      if (in_if.in_rsc_vld && m_open) begin
        nx_we  = NB'(1) << (cnt % NB);
        e_addr = AW'(cnt / NB);
        e_dat  = in_if.in_rsc_dat;
`ifdef MLP_WLOAD_CHECKSUM_EN
        e_sum  = e_sum + 32'($signed(in_if.in_rsc_dat));
`endif
        void'(wq.pop_front());
        cnt++;
        if (cnt == total) begin
          m_open  = 0;
          nx_done = 1;
        end
      end
      if (start) begin
        if (idle && num_rows >= 1 && num_rows <= BD) begin
          m_open = 1;
          cnt    = 0;
          total  = int'(num_rows) * NB;
          e_sum  = '0;
        end else begin
          nx_err = 1;
        end
      end
      e_we   = nx_we;
      e_done = nx_done;
      e_err  = nx_err;
      e_busy = m_open;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    bit want;
    case (vld_mode)
      0:       want = 1;
      1:       begin want = phase; phase = !phase; end
      default: want = 1'($urandom_range(0, 1));
    endcase
    in_if.in_rsc_vld = want && (wq.size() > 0);
    in_if.in_rsc_dat = in_if.in_rsc_vld ? wq[0] : DW'($urandom);
    tick();
  endtask

  task automatic start_load(input int n);
    start    = 1;
    num_rows = (AW+1)'(n);
    cyc();
    start    = 0;
  endtask

  task automatic run_until_idle(input int budget, input bit spur);
    int b = budget;
    while ((m_open || e_done) && b > 0) begin
      if (spur && $urandom_range(0, 15) == 0) begin
        start    = 1;
        num_rows = (AW+1)'($urandom_range(0, 9));
      end
      cyc();
      start = 0;
      b--;
    end
    if (m_open || e_done) check("load_timeout", 32'(1), 32'(0));
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
  endtask

  initial begin
    int n;
    rst = 1; start = 0; num_rows = '0;
    in_if.in_rsc_vld = 0; in_if.in_rsc_dat = '0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 0;
    tick();

    // Basic load: 0x01..0x08 over two rows, valid held high
    for (int i = 1; i <= 8; i++) wq.push_back(DW'(i));
    vld_mode = 0; n_wr = 0;
    start_load(2);
    run_until_idle(100, 0);
    check("basic_writes", 32'(n_wr), 32'(8));
    cyc();

    // Stall and wrap: full depth, valid toggling every cycle
    push_random(32);
    vld_mode = 1; phase = 1; n_wr = 0;
    start_load(8);
    run_until_idle(200, 0);
    check("stall_writes", 32'(n_wr), 32'(32));
    check("stall_last_we", 32'(last_we), 32'(4'b1000));
    check("stall_last_addr", 32'(last_addr), 32'(7));
    cyc();

    // Illegal starts
    vld_mode = 0; n_wr = 0;
    start_load(0);
    cyc(); cyc();
    start_load(9);
    cyc(); cyc();
    check("illegal_no_writes", 32'(n_wr), 32'(0));

    // Start during LOAD after word 3 is rejected, load carries on
    push_random(8);
    n_wr = 0;
    start_load(2);
    while (cnt < 3 && m_open) cyc();
    start = 1; num_rows = 1;
    cyc();
    start = 0;
    run_until_idle(100, 0);
    check("busy_start_writes", 32'(n_wr), 32'(8));
    cyc();

    // Reset after word 5 of 8, then a one-row load
    push_random(8);
    start_load(2);
    while (cnt < 5 && m_open) cyc();
    rst = 1;
    cyc();
    rst = 0;
    wq.delete();
    cyc();
    push_random(4);
    n_wr = 0;
    start_load(1);
    run_until_idle(100, 0);
    check("post_reset_writes", 32'(n_wr), 32'(4));
    check("post_reset_last_addr", 32'(last_addr), 32'(0));
    check("post_reset_last_we", 32'(last_we), 32'(4'b1000));
    cyc();

    // Overrun: ten valid words offered for an eight-word load
    push_random(10);
    n_wr = 0;
    start_load(2);
    run_until_idle(100, 0);
    cyc(); cyc(); cyc();
    check("overrun_writes", 32'(n_wr), 32'(8));
    check("overrun_rdy", 32'(in_if.in_rsc_rdy), 32'(0));
    wq.delete();
    cyc();

    // Checksum of 0x7F + 0x01 - 0x01 - 0x80
    wq.push_back(8'h7F); wq.push_back(8'h01); wq.push_back(8'hFF); wq.push_back(8'h80);
    start_load(1);
    run_until_idle(100, 0);
`ifdef MLP_WLOAD_CHECKSUM_EN
    check("checksum_final", checksum, 32'hFFFF_FFFF);
`else
    check("checksum_final", checksum, 32'h0);
`endif
    cyc();

    // Random loads with random valid gaps and stray starts
    vld_mode = 2;
    repeat (20) begin
      n = $urandom_range(0, 9);
      push_random(((n >= 1 && n <= BD) ? n * NB : 0) + $urandom_range(0, 2));
      n_wr = 0;
      start_load(n);
      run_until_idle(400, 1);
      cyc(); cyc();
      check("random_writes", 32'(n_wr), (n >= 1 && n <= BD) ? 32'(n * NB) : 32'(0));
      wq.delete();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
